// File: rtl/issue_ctrl.sv
// In-order fetch/issue sequencer for the Tomasulo core. Walks PC through
// instruction memory, decodes each word and allocates the lowest-index free
// reservation station of the add/sub or mul pool, stalling while none is free.
module issue_ctrl #(
    parameter int PROG_LEN = 6,
    parameter int N_ADD_RS = 3,
    parameter int N_MUL_RS = 2
) (
    input  logic                clk1,
    input  logic                rst_n,
    input  logic                start,
    output logic [3:0]          imem_addr,
    input  logic [15:0]         imem_data,
    input  logic [N_ADD_RS-1:0] add_rs_free,
    input  logic [N_MUL_RS-1:0] mul_rs_free,
    output logic                issue_valid,
    output logic                issue_unit,
    output logic [1:0]          issue_rs_idx,
    output logic [3:0]          issue_op,
    output logic [3:0]          issue_src1,
    output logic [3:0]          issue_src2,
    output logic [3:0]          issue_dst,
    output logic                stall_bit,
    output logic                illegal,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DONE
    } state_e;

    typedef struct packed {
        logic       unit;
        logic [1:0] rs_idx;
        logic [3:0] op;
        logic [3:0] src1;
        logic [3:0] src2;
        logic [3:0] dst;
    } issue_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] LAST_PC = 4'(PROG_LEN - 1);

    state_e      state_q, state_d;
    logic [3:0]  pc_q, pc_d;
    logic [15:0] hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        issue_valid_q, issue_valid_d;
    issue_t      issue_q, issue_d;
    logic        stall_q, stall_d;
    logic        illegal_q, illegal_d;
    logic        done_q, done_d;

    logic [15:0] word;
    logic        is_add, is_mul;
    logic        add_any, mul_any;
    logic [1:0]  add_idx, mul_idx;
    logic        pool_any;
    logic [1:0]  pool_idx;

    // Decode the held word; on the first ISSUE cycle it is still on the memory bus.
    always_comb begin
        word   = hold_vld_q ? hold_q : imem_data;
        is_add = (word[15:12] == OP_ADD) || (word[15:12] == OP_SUB);
        is_mul = (word[15:12] == OP_MUL);
    end

    // Lowest-index free station per pool; scanning downward lets the lowest index win.
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise a
        // path that skips the assignment infers a latch.
        add_any = 1'b0;
        add_idx = 2'd0;
        mul_any = 1'b0;
        mul_idx = 2'd0;
        for (int i = N_ADD_RS - 1; i >= 0; i--) begin
            if (add_rs_free[i]) begin
                add_any = 1'b1;
                add_idx = 2'(i);
            end
        end
        for (int i = N_MUL_RS - 1; i >= 0; i--) begin
            if (mul_rs_free[i]) begin
                mul_any = 1'b1;
                mul_idx = 2'(i);
            end
        end
        pool_any = is_mul ? mul_any : add_any;
        pool_idx = is_mul ? mul_idx : add_idx;
    end

    // Next-state, PC advance and issue decision.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_d        = hold_q;
        hold_vld_d    = hold_vld_q;
        issue_valid_d = 1'b0;
        issue_d       = issue_q;
        stall_d       = 1'b0;
        illegal_d     = illegal_q;
        done_d        = done_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = 4'd0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                hold_vld_d = 1'b0;
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                hold_d     = word;
                hold_vld_d = 1'b1;
                if (!(is_add || is_mul) || pool_any) begin
                    if (!(is_add || is_mul)) begin
                        illegal_d = 1'b1;
                    end else begin
                        issue_valid_d  = 1'b1;
                        issue_d.unit   = is_mul;
                        issue_d.rs_idx = pool_idx;
                        issue_d.op     = word[15:12];
                        issue_d.src1   = word[11:8];
                        issue_d.src2   = word[7:4];
                        issue_d.dst    = word[3:0];
                    end
                    // The last word goes to DONE before PC could ever wrap.
                    if (pc_q == LAST_PC) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        pc_d    = pc_q + 4'd1;
                        state_d = S_FETCH;
                    end
                end else begin
                    stall_d = 1'b1;
                end
            end
            S_DONE: begin
                if (start) begin
                    done_d  = 1'b0;
                    pc_d    = 4'd0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset clears everything including the held word.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= 4'd0;
            // NOTE: the hold register is reset so a mid-program reset cannot
            // leave a stale instruction to be re-decoded after restart.
            hold_q        <= 16'd0;
            hold_vld_q    <= 1'b0;
            issue_valid_q <= 1'b0;
            issue_q       <= '0;
            stall_q       <= 1'b0;
            illegal_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others.
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_q        <= hold_d;
            hold_vld_q    <= hold_vld_d;
            issue_valid_q <= issue_valid_d;
            issue_q       <= issue_d;
            stall_q       <= stall_d;
            illegal_q     <= illegal_d;
            done_q        <= done_d;
        end
    end

    assign imem_addr    = pc_q;
    assign issue_valid  = issue_valid_q;
    assign issue_unit   = issue_q.unit;
    assign issue_rs_idx = issue_q.rs_idx;
    assign issue_op     = issue_q.op;
    assign issue_src1   = issue_q.src1;
    assign issue_src2   = issue_q.src2;
    assign issue_dst    = issue_q.dst;
    assign stall_bit    = stall_q;
    assign illegal      = illegal_q;
    assign done         = done_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: default program, pool stalls, illegal skip,
// mid-program reset and start handling in ISSUE and DONE.
module tb_issue_ctrl;

    logic        clk1;
    logic        rst_n;
    logic        start;
    logic [3:0]  imem_addr;
    logic [15:0] imem_data;
    logic [2:0]  add_rs_free;
    logic [1:0]  mul_rs_free;
    logic        issue_valid;
    logic        issue_unit;
    logic [1:0]  issue_rs_idx;
    logic [3:0]  issue_op;
    logic [3:0]  issue_src1;
    logic [3:0]  issue_src2;
    logic [3:0]  issue_dst;
    logic        stall_bit;
    logic        illegal;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [16];
    logic [15:0] prog1 [6];

    issue_ctrl #(.PROG_LEN(6), .N_ADD_RS(3), .N_MUL_RS(2)) dut (
        .clk1         (clk1),
        .rst_n        (rst_n),
        .start        (start),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .add_rs_free  (add_rs_free),
        .mul_rs_free  (mul_rs_free),
        .issue_valid  (issue_valid),
        .issue_unit   (issue_unit),
        .issue_rs_idx (issue_rs_idx),
        .issue_op     (issue_op),
        .issue_src1   (issue_src1),
        .issue_src2   (issue_src2),
        .issue_dst    (issue_dst),
        .stall_bit    (stall_bit),
        .illegal      (illegal),
        .done         (done)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    // Synchronous-read instruction memory.
    initial imem_data = 16'd0;
    always @(posedge clk1) imem_data <= mem[imem_addr];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk1);
    endtask

    // Run until done (bounded), counting issue pulses.
    task automatic run_to_done(input string tag, input int exp_issues);
        int n = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            step();
            if (issue_valid) n++;
        end
        check({tag, "_done"}, 16'(done), 16'd1);
        check({tag, "_issues"}, 16'(n), 16'(exp_issues));
    endtask

    task automatic check_issue(input string tag, input logic [15:0] w, input logic unit,
                               input logic [1:0] idx);
        check({tag, "_valid"}, 16'(issue_valid), 16'd1);
        check({tag, "_unit"}, 16'(issue_unit), 16'(unit));
        check({tag, "_idx"}, 16'(issue_rs_idx), 16'(idx));
        check({tag, "_op"}, 16'(issue_op), 16'(w[15:12]));
        check({tag, "_src1"}, 16'(issue_src1), 16'(w[11:8]));
        check({tag, "_src2"}, 16'(issue_src2), 16'(w[7:4]));
        check({tag, "_dst"}, 16'(issue_dst), 16'(w[3:0]));
    endtask

    initial begin
        logic [15:0] w;
        int stall_seen;

        rst_n       = 1'b0;
        start       = 1'b0;
        add_rs_free = 3'b111;
        mul_rs_free = 2'b11;
        prog1[0] = 16'h0123; prog1[1] = 16'h0456; prog1[2] = 16'h0789;
        prog1[3] = 16'h2ABC; prog1[4] = 16'h2DEF; prog1[5] = 16'h1321;
        for (int i = 0; i < 16; i++) mem[i] = (i < 6) ? prog1[i] : 16'h0000;

        // Reset state
        step();
        check("rst_addr", 16'(imem_addr), 16'd0);
        check("rst_valid", 16'(issue_valid), 16'd0);
        check("rst_stall", 16'(stall_bit), 16'd0);
        check("rst_illegal", 16'(illegal), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        rst_n = 1'b1;

        // 1: default program, all stations free, 2-cycle issue spacing
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1_fetch_addr", 16'(imem_addr), 16'd0);
        check("t1_fetch_valid", 16'(issue_valid), 16'd0);
        step();
        check("t1_issue_state_valid", 16'(issue_valid), 16'd0);
        stall_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (k != 0) begin
                step();
                check($sformatf("t1_gap%0d_valid", k), 16'(issue_valid), 16'd0);
                if (stall_bit) stall_seen++;
            end
            step();
            if (stall_bit) stall_seen++;
            w = prog1[k];
            check_issue($sformatf("t1_i%0d", k), w, (w[15:12] == 4'h2), 2'd0);
            check($sformatf("t1_i%0d_addr", k), 16'(imem_addr), (k == 5) ? 16'd5 : 16'(k + 1));
        end
        check("t1_done", 16'(done), 16'd1);
        check("t1_no_stall", 16'(stall_seen), 16'd0);

        // 2: mul stalls with no free mul station, then issues to idx 1
        mem[0] = 16'h2123; mem[1] = 16'h0456; mem[2] = 16'hF123;
        mem[3] = 16'h0789; mem[4] = 16'h1321; mem[5] = 16'h2ABC;
        mul_rs_free = 2'b00;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t6_rerun_done", 16'(done), 16'd0);
        check("t6_rerun_addr", 16'(imem_addr), 16'd0);
        step();
        step();
        check("t2_stall", 16'(stall_bit), 16'd1);
        check("t2_stall_valid", 16'(issue_valid), 16'd0);
        step();
        check("t2_stall2", 16'(stall_bit), 16'd1);
        mul_rs_free = 2'b10;
        step();
        check_issue("t2_mul", 16'h2123, 1'b1, 2'd1);
        check("t2_unstall", 16'(stall_bit), 16'd0);

        // 3: add to idx 1
        add_rs_free = 3'b110;
        step();
        step();
        check_issue("t3_add", 16'h0456, 1'b0, 2'd1);

        // 4: illegal word at PC 2 is skipped, PC 3 fetched
        step();
        step();
        check("t4_illegal", 16'(illegal), 16'd1);
        check("t4_valid", 16'(issue_valid), 16'd0);
        check("t4_addr", 16'(imem_addr), 16'd3);
        check("t4_hold_dst", 16'(issue_dst), 16'h6);
        check("t4_hold_idx", 16'(issue_rs_idx), 16'd1);

        // 3b: add pool empty stalls even with mul pool free
        add_rs_free = 3'b000;
        mul_rs_free = 2'b11;
        step();
        step();
        check("t3_add_stall", 16'(stall_bit), 16'd1);
        check("t3_add_stall_valid", 16'(issue_valid), 16'd0);
        check("t4_illegal_sticky", 16'(illegal), 16'd1);

        // 6a: start during ISSUE is ignored
        start = 1'b1;
        step();
        start = 1'b0;
        check("t6_ign_stall", 16'(stall_bit), 16'd1);
        check("t6_ign_addr", 16'(imem_addr), 16'd3);
        check("t6_ign_done", 16'(done), 16'd0);

        // 5: asynchronous reset during the stall
        #1 rst_n = 1'b0;
        #1;
        check("t5_addr", 16'(imem_addr), 16'd0);
        check("t5_stall", 16'(stall_bit), 16'd0);
        check("t5_illegal", 16'(illegal), 16'd0);
        check("t5_dst", 16'(issue_dst), 16'd0);
        check("t5_valid", 16'(issue_valid), 16'd0);
        step();
        rst_n = 1'b1;
        add_rs_free = 3'b111;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t5_refetch_addr", 16'(imem_addr), 16'd0);
        step();
        step();
        check_issue("t5_first", 16'h2123, 1'b1, 2'd0);
        run_to_done("t5_run", 4);
        check("t5_run_illegal", 16'(illegal), 16'd1);

        // 6b: start in DONE reruns; illegal is kept
        start = 1'b1;
        step();
        start = 1'b0;
        check("t6b_done", 16'(done), 16'd0);
        check("t6b_addr", 16'(imem_addr), 16'd0);
        check("t6b_illegal_kept", 16'(illegal), 16'd1);
        run_to_done("t6b_run", 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
